// File: rtl/fifo_ctrl.sv
// FIFO pointer/count controller for an external synchronous RAM with one-cycle read latency.
// Produces RAM enables and addresses, registered occupancy flags and sticky error flags.
module fifo_ctrl #(
  parameter int unsigned DATA_SIZE       = 6,
  parameter int unsigned MAIN_QUEUE_SIZE = 3,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  output logic                       write,
  output logic                       read,
  output logic [MAIN_QUEUE_SIZE-1:0] wr_ptr,
  output logic [MAIN_QUEUE_SIZE-1:0] rd_ptr,
  output logic [MAIN_QUEUE_SIZE:0]   count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       valid_out,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int unsigned PtrW  = MAIN_QUEUE_SIZE;
  localparam int unsigned CntW  = MAIN_QUEUE_SIZE + 1;
  localparam int unsigned Depth = 2 ** MAIN_QUEUE_SIZE;

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfTh     = CntW'(ALMOST_FULL_TH);
  localparam logic [CntW-1:0] AeTh     = CntW'(ALMOST_EMPTY_TH);

  // The RAM word width only matters to the integrator; nothing here depends on it.
  if (DATA_SIZE == 0) begin : g_no_data_width
  end

  logic            push_ok, pop_ok;
  logic [PtrW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic            full_d, full_q, empty_d, empty_q;
  logic            almost_full_d, almost_full_q, almost_empty_d, almost_empty_q;
  logic            valid_d, valid_q, overflow_d, overflow_q, underflow_d, underflow_q;

  always_comb begin
    // Reset masks the enables so the RAM is never touched while the block is being cleared.
    pop_ok  = pop && !empty_q && !reset;
    push_ok = push && (!full_q || pop_ok) && !reset;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    full_d         = (count_d == DepthCnt);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AfTh);
    almost_empty_d = (count_d <= AeTh);

    valid_d     = pop_ok;
    overflow_d  = overflow_q || (push && full_q && !pop);
    underflow_d = underflow_q || (pop && empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      valid_q        <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      valid_q        <= valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign write         = push_ok;
  assign read          = pop_ok;
  assign wr_ptr        = wr_ptr_q;
  assign rd_ptr        = rd_ptr_q;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign almost_full   = almost_full_q;
  assign almost_empty  = almost_empty_q;
  assign valid_out     = valid_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: hand-computed vector table, then a randomised run against a reference
// model; a small RAM plus a data scoreboard checks that words come back in order.
module tb_fifo_ctrl;

  localparam int unsigned Dw = 6;
  localparam int unsigned Aw = 3;

  logic          clk = 1'b0;
  logic          reset, push, pop;
  logic          write, read;
  logic [Aw-1:0] wr_ptr, rd_ptr;
  logic [Aw:0]   count;
  logic          full, empty, almost_full, almost_empty, valid_out, overflow_err, underflow_err;

  logic [Dw-1:0] din, ram_dout;
  logic [Dw-1:0] mem [2**Aw];

  int n_chk  = 0;
  int n_fail = 0;
  logic [Dw-1:0] sb_q[$];

  always #5 clk = ~clk;

  fifo_ctrl #(
    .DATA_SIZE      (Dw),
    .MAIN_QUEUE_SIZE(Aw),
    .ALMOST_FULL_TH (6),
    .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .valid_out    (valid_out),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  // Attached RAM: read-before-write on the same address.
  always @(posedge clk) begin
    if (read)  ram_dout <= mem[rd_ptr];
    if (write) mem[wr_ptr] <= din;
  end

  typedef struct {
    logic       rst, psh, pp;
    logic       ew, er;
    logic [3:0] cnt;
    logic [2:0] wp, rp;
    logic [6:0] flg;  // {full, empty, almost_full, almost_empty, valid_out, overflow, underflow}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, psh, pp, ew, er, input int cnt, wp, rp,
                     input logic [6:0] flg);
    vec_t v;
    v.rst = rst; v.psh = psh; v.pp = pp; v.ew = ew; v.er = er;
    v.cnt = 4'(cnt); v.wp = 3'(wp); v.rp = 3'(rp); v.flg = flg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] dut_flags();
    return {full, empty, almost_full, almost_empty, valid_out, overflow_err, underflow_err};
  endfunction

  task automatic sb_check();
    if (valid_out) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data: valid_out with no word expected");
      end else begin
        logic [Dw-1:0] e;
        e = sb_q.pop_front();
        n_chk--;
        chk("rd_data", 32'(ram_dout), 32'(e));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int m_cnt, m_wp, m_rp;
    logic m_vld, m_ovf, m_unf, pok, wok;

    reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;

    //    rst psh pop ew er cnt wp rp  flags
    add(1, 1, 0, 0, 0, 0, 0, 0, 7'b0101000);  // reset beats push
    add(0, 1, 0, 1, 0, 1, 1, 0, 7'b0001000);
    add(0, 1, 0, 1, 0, 2, 2, 0, 7'b0001000);
    add(0, 1, 0, 1, 0, 3, 3, 0, 7'b0000000);
    add(0, 1, 0, 1, 0, 4, 4, 0, 7'b0000000);
    add(0, 1, 0, 1, 0, 5, 5, 0, 7'b0000000);
    add(0, 1, 0, 1, 0, 6, 6, 0, 7'b0010000);
    add(0, 1, 0, 1, 0, 7, 7, 0, 7'b0010000);
    add(0, 1, 0, 1, 0, 8, 0, 0, 7'b1010000);  // full, wr_ptr wrapped
    add(0, 1, 0, 0, 0, 8, 0, 0, 7'b1010010);  // overflow
    add(0, 0, 0, 0, 0, 8, 0, 0, 7'b1010010);  // overflow sticky
    add(0, 1, 1, 1, 1, 8, 1, 1, 7'b1010110);  // full push+pop
    add(0, 1, 1, 1, 1, 8, 2, 2, 7'b1010110);
    add(0, 1, 1, 1, 1, 8, 3, 3, 7'b1010110);
    add(0, 0, 0, 0, 0, 8, 3, 3, 7'b1010010);
    add(1, 1, 0, 0, 0, 0, 0, 0, 7'b0101000);
    add(0, 1, 1, 1, 0, 1, 1, 0, 7'b0001001);  // empty push+pop: no bypass
    add(0, 0, 0, 0, 0, 1, 1, 0, 7'b0001001);
    add(0, 1, 0, 1, 0, 2, 2, 0, 7'b0001001);
    add(0, 1, 0, 1, 0, 3, 3, 0, 7'b0000001);
    add(0, 1, 0, 1, 0, 4, 4, 0, 7'b0000001);
    add(0, 1, 0, 1, 0, 5, 5, 0, 7'b0000001);
    add(0, 0, 1, 0, 1, 4, 5, 1, 7'b0000101);  // drain five
    add(0, 0, 1, 0, 1, 3, 5, 2, 7'b0000101);
    add(0, 0, 1, 0, 1, 2, 5, 3, 7'b0001101);
    add(0, 0, 1, 0, 1, 1, 5, 4, 7'b0001101);
    add(0, 0, 1, 0, 1, 0, 5, 5, 7'b0101101);
    add(0, 0, 0, 0, 0, 0, 5, 5, 7'b0101001);
    add(0, 0, 1, 0, 0, 0, 5, 5, 7'b0101001);  // pop on empty rejected
    add(0, 1, 0, 1, 0, 1, 6, 5, 7'b0001001);
    add(0, 1, 0, 1, 0, 2, 7, 5, 7'b0001001);
    add(0, 1, 0, 1, 0, 3, 0, 5, 7'b0000001);
    add(0, 1, 0, 1, 0, 4, 1, 5, 7'b0000001);
    add(1, 1, 0, 0, 0, 0, 0, 0, 7'b0101000);  // reset mid-operation
    add(0, 1, 0, 1, 0, 1, 1, 0, 7'b0001000);  // first push after reset at address 0

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; push = vecs[i].psh; pop = vecs[i].pp;
      din = Dw'($urandom);
      #1;
      chk($sformatf("write[%0d]", i), 32'(write), 32'(vecs[i].ew));
      chk($sformatf("read[%0d]", i), 32'(read), 32'(vecs[i].er));
      if (vecs[i].ew) sb_q.push_back(din);
      @(posedge clk);
      #1;
      if (vecs[i].rst) sb_q.delete();
      chk($sformatf("count[%0d]", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("wr_ptr[%0d]", i), 32'(wr_ptr), 32'(vecs[i].wp));
      chk($sformatf("rd_ptr[%0d]", i), 32'(rd_ptr), 32'(vecs[i].rp));
      chk($sformatf("flags[%0d]", i), 32'(dut_flags()), 32'(vecs[i].flg));
      sb_check();
    end

    // Randomised run against a reference model.
    @(negedge clk);
    reset = 1'b1; push = 1'b0; pop = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset = 1'b0;
      // Bias the mix by phase so both full and empty regions are exercised.
      push = ($urandom_range(0, 99) < ((c / 50) % 2 == 0 ? 75 : 30));
      pop  = ($urandom_range(0, 99) < ((c / 50) % 2 == 0 ? 30 : 75));
      if (c == 399) begin push = 1'b0; pop = 1'b0; end
      din  = Dw'($urandom);
      pok  = pop && (m_cnt != 0);
      wok  = push && ((m_cnt != 8) || pok);
      #1;
      chk("rnd_write", 32'(write), 32'(wok));
      chk("rnd_read", 32'(read), 32'(pok));
      if (wok) sb_q.push_back(din);
      if (push && m_cnt == 8 && !pop) m_ovf = 1'b1;
      if (pop && m_cnt == 0) m_unf = 1'b1;
      if (wok && !pok) m_cnt++;
      if (pok && !wok) m_cnt--;
      if (wok) m_wp = (m_wp + 1) % 8;
      if (pok) m_rp = (m_rp + 1) % 8;
      m_vld = pok;
      @(posedge clk);
      #1;
      chk("rnd_count", 32'(count), 32'(m_cnt));
      chk("rnd_wr_ptr", 32'(wr_ptr), 32'(m_wp));
      chk("rnd_rd_ptr", 32'(rd_ptr), 32'(m_rp));
      chk("rnd_flags", 32'(dut_flags()),
          32'({m_cnt == 8, m_cnt == 0, m_cnt >= 6, m_cnt <= 2, m_vld, m_ovf, m_unf}));
      sb_check();
    end
    chk("rnd_sb_depth", 32'(sb_q.size()), 32'(m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DATA_SIZE, default 6: word width of the attached RAM; carried for integration only, no data passes through this block.
REQ-002 Parameter MAIN_QUEUE_SIZE, default 3: pointer width; DEPTH = 2**MAIN_QUEUE_SIZE.
REQ-003 Parameter ALMOST_FULL_TH, default 6: count at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_TH, default 2: count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 push  input  1  upstream write request.
REQ-008 pop  input  1  downstream read request.
REQ-009 write  output  1  RAM write enable (combinational).
REQ-010 read  output  1  RAM read enable (combinational).
REQ-011 wr_ptr  output  MAIN_QUEUE_SIZE  RAM write address (registered).
REQ-012 rd_ptr  output  MAIN_QUEUE_SIZE  RAM read address (registered).
REQ-013 count  output  MAIN_QUEUE_SIZE+1  stored words, 0..DEPTH.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  registered status flags.
REQ-015 valid_out  output  1  RAM data_out valid this cycle.
REQ-016 overflow_err, underflow_err  output  1 each  sticky error flags.

Function
REQ-017 push_ok = push && (!full || pop_ok); pop_ok = pop && !empty; write = push_ok; read = pop_ok.
REQ-018 On push_ok, wr_ptr increments by 1, modulo DEPTH (DEPTH-1 wraps to 0).
REQ-019 On pop_ok, rd_ptr increments by 1, modulo DEPTH.
REQ-020 count: +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither.
REQ-021 Flags computed from next-cycle count, registered: full = (count==DEPTH), empty = (count==0), almost_full = (count>=ALMOST_FULL_TH), almost_empty = (count<=ALMOST_EMPTY_TH).
REQ-022 Full with push and pop in same cycle: both accepted, RAM returns old word at rd_ptr, new word overwrites same address; count stays DEPTH.
REQ-023 Empty with push and pop in same cycle: push accepted, pop rejected (no bypass), underflow_err set; count becomes 1.
REQ-024 valid_out asserts exactly one cycle after each pop_ok (matches one-cycle RAM read latency), deasserts otherwise.
REQ-025 overflow_err sets on push && full && !pop; underflow_err sets on pop && empty; both hold until reset.
REQ-026 Rejected requests change no pointer, count or non-error flag.

Reset
REQ-027 When reset is high at a rising edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, valid_out=0, overflow_err=0, underflow_err=0.
REQ-028 Reset overrides push/pop in the same cycle; write and read SHALL be 0 while reset is high.
REQ-029 Reset mid-operation discards all stored words; post-reset, first push writes address 0.

Verification
REQ-030 Reset, then 8 pushes, no pops -> wr_ptr 0..7 then 0, count=8, full=1 after 8th edge, almost_full=1 after 6th, empty=0 after 1st.
REQ-031 From full, push only -> write=0, count=8, overflow_err=1 and stays 1 after push drops.
REQ-032 From full, push+pop for 3 cycles -> count=8, full=1, rd_ptr and wr_ptr both advance to 3, valid_out=1 each following cycle.
REQ-033 From empty, push+pop together -> count=1, read=0, underflow_err=1, valid_out=0 next cycle.
REQ-034 Fill to 5, pop 5 -> count 5..0, almost_empty=1 at count 2, empty=1 at 0, valid_out high 5 consecutive cycles lagging pops by one.
REQ-035 Fill to 4, assert reset with push=1 -> next cycle count=0, wr_ptr=0, empty=1, errors=0, write=0 during reset.
